// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life datapath: neighbour status layout
// and the frame scanner's state encoding.
package life_pkg;

  localparam int STATUS_W = 9;

  // Bit positions inside a neighbourhood status vector.
  localparam int CENTER = 0;
  localparam int NW     = 1;
  localparam int N      = 2;
  localparam int NE     = 3;
  localparam int W      = 4;
  localparam int E      = 5;
  localparam int SW     = 6;
  localparam int S      = 7;
  localparam int SE     = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD0,
    LOAD1,
    LOAD2,
    CAP,
    STREAM,
    FETCH,
    SHIFT
  } scan_state_e;

endpackage

// File: rtl/neighborhood_scanner_window_extract.sv
// Combinational 3x3 neighbourhood picker: selects the nine cells around
// column x from three buffered rows, applying wrap or dead-edge handling.
module window_extract
  import life_pkg::*;
#(
  parameter int WIDTH = 100,
  parameter bit WRAP  = 1'b0,
  parameter int COL_W = 7
) (
  input  logic [WIDTH-1:0]    top_row,
  input  logic [WIDTH-1:0]    mid_row,
  input  logic [WIDTH-1:0]    bot_row,
  input  logic [COL_W-1:0]    x,
  output logic [STATUS_W-1:0] status
);

  localparam logic [COL_W-1:0] X_LAST = COL_W'(WIDTH - 1);

  logic [COL_W-1:0] xw;
  logic [COL_W-1:0] xe;
  logic             w_ok;
  logic             e_ok;

  // Edge columns either wrap to the opposite side or read as dead cells.
  always_comb begin
    xw   = x - 1'b1;
    xe   = x + 1'b1;
    w_ok = 1'b1;
    e_ok = 1'b1;
    if (x == '0) begin
      xw   = X_LAST;
      w_ok = WRAP;
    end
    if (x == X_LAST) begin
      xe   = '0;
      e_ok = WRAP;
    end
  end

  always_comb begin
    status         = '0;
    status[CENTER] = mid_row[x];
    status[NW]     = w_ok & top_row[xw];
    status[N]      = top_row[x];
    status[NE]     = e_ok & top_row[xe];
    status[W]      = w_ok & mid_row[xw];
    status[E]      = e_ok & mid_row[xe];
    status[SW]     = w_ok & bot_row[xw];
    status[S]      = bot_row[x];
    status[SE]     = e_ok & bot_row[xe];
  end

endmodule

// File: rtl/neighborhood_scanner.sv
// Frame reader: walks the generation grid row-major with a three-row buffer
// and streams one neighbourhood window per cell with x/y/last sideband.
module neighborhood_scanner
  import life_pkg::*;
#(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100,
  parameter bit WRAP   = 1'b0,
  parameter int ROW_AW = 7,
  parameter int COL_W  = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [ROW_AW-1:0]   rd_addr,
  input  logic [WIDTH-1:0]    rd_data,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [STATUS_W-1:0] win_status,
  output logic [COL_W-1:0]    win_x,
  output logic [ROW_AW-1:0]   win_y,
  output logic                win_last
);

  localparam logic [COL_W-1:0]  X_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_AW-1:0] Y_LAST = ROW_AW'(HEIGHT - 1);

  scan_state_e state;
  scan_state_e state_n;

  logic [COL_W-1:0]  x;
  logic [ROW_AW-1:0] y;
  logic [WIDTH-1:0]  top_q;
  logic [WIDTH-1:0]  mid_q;
  logic [WIDTH-1:0]  bot_q;
  logic              rd_valid_q;
  logic              done_q;
  logic [WIDTH-1:0]  cap_row;
  logic              hs;
  logic              row_end;
  logic [ROW_AW:0]   y_plus2;
  logic              fetch_in_range;
  logic [ROW_AW-1:0] fetch_addr;

  // Window handshake: a window transfers on any rising edge where win_valid
  // and win_ready are both high; while win_valid is high and win_ready is
  // low every win_* output holds, and win_valid never drops without a transfer.
  assign hs      = win_valid & win_ready;
  assign row_end = (x == X_LAST);

  // Suppressed read slots capture zeros, giving dead rows beyond the frame.
  assign cap_row = rd_valid_q ? rd_data : '0;

  // y+2 only reaches HEIGHT on the second-to-last row, which wraps to row 0.
  assign y_plus2        = {1'b0, y} + (ROW_AW + 1)'(2);
  assign fetch_in_range = (y_plus2 < (ROW_AW + 1)'(HEIGHT));
  assign fetch_addr     = fetch_in_range ? y_plus2[ROW_AW-1:0] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (start) state_n = LOAD0;
      LOAD0:  state_n = LOAD1;
      LOAD1:  state_n = LOAD2;
      LOAD2:  state_n = CAP;
      CAP:    state_n = STREAM;
      STREAM: begin
        if (hs && row_end) begin
          state_n = (y == Y_LAST) ? IDLE : FETCH;
        end
      end
      FETCH:  state_n = SHIFT;
      SHIFT:  state_n = STREAM;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rd_en     = 1'b0;
    rd_addr   = '0;
    win_valid = 1'b0;
    case (state)
      LOAD0: begin
        // The scan always starts at y = 0, so the top row is HEIGHT-1 or dead.
        if (WRAP) begin
          rd_en   = 1'b1;
          rd_addr = Y_LAST;
        end
      end
      LOAD1: begin
        rd_en   = 1'b1;
        rd_addr = '0;
      end
      LOAD2: begin
        rd_en   = 1'b1;
        rd_addr = ROW_AW'(1);
      end
      FETCH: begin
        if (WRAP || fetch_in_range) begin
          rd_en   = 1'b1;
          rd_addr = fetch_addr;
        end
      end
      STREAM: win_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x          <= '0;
      y          <= '0;
      top_q      <= '0;
      mid_q      <= '0;
      bot_q      <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      done_q     <= hs & win_last;
      case (state)
        IDLE: begin
          if (start) begin
            x <= '0;
            y <= '0;
          end
        end
        LOAD1: top_q <= cap_row;
        LOAD2: mid_q <= cap_row;
        CAP:   bot_q <= cap_row;
        STREAM: begin
          if (hs) begin
            if (row_end) begin
              x <= '0;
              if (y == Y_LAST) y <= '0;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        SHIFT: begin
          top_q <= mid_q;
          mid_q <= bot_q;
          bot_q <= cap_row;
          y     <= y + 1'b1;
        end
        default: ;
      endcase
    end
  end

  window_extract #(
    .WIDTH (WIDTH),
    .WRAP  (WRAP),
    .COL_W (COL_W)
  ) u_extract (
    .top_row (top_q),
    .mid_row (mid_q),
    .bot_row (bot_q),
    .x       (x),
    .status  (win_status)
  );

  assign busy     = (state != IDLE);
  assign done     = done_q;
  assign win_x    = x;
  assign win_y    = y;
  assign win_last = win_valid & row_end & (y == Y_LAST);

endmodule
